// File: rtl/ppu_vmem_arbiter.sv
// rtl/ppu_vmem_arbiter.sv - video-memory port arbiter with OAM DMA engine and PPU-mode access locking
module ppu_vmem_arbiter #(
    parameter int DMA_LEN         = 160,
    parameter int DMA_START_DELAY = 1     // must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [7:0]  CPU_DATA_out,
    output logic [7:0]  CPU_DATA_in,
    input  logic [1:0]  PPU_MODE,
    input  logic        PPU_RD,
    input  logic [15:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA_in,
    output logic [15:0] SYS_ADDR,
    output logic        SYS_RD,
    input  logic [7:0]  SYS_DATA,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    output logic        MEM_WR,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    output logic        DMA_ACTIVE
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_WR    = 2'd3;

    localparam logic [1:0] MODE_SCAN = 2'd2;
    localparam logic [1:0] MODE_DRAW = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [7:0] DLY_INIT = 8'(DMA_START_DELAY - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  dly_q, dly_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [15:0] sys_addr_q, sys_addr_d;
    logic        rd_vld_q, rd_vld_d;
    logic        rd_own_q, rd_own_d;     // 1 = PPU owns the returning read, 0 = CPU

    logic cpu_vram, cpu_oam, ppu_oam;
    logic dma_trig, dma_active, dma_wr;
    logic ppu_grant, cpu_req, cpu_locked, cpu_grant;
    logic mem_rd_c, mem_wr_c, sys_rd_c;

    assign cpu_vram   = (CPU_ADDR[15:13] == 3'b100);
    assign cpu_oam    = (CPU_ADDR >= 16'hFE00) && (CPU_ADDR <= 16'hFE9F);
    assign ppu_oam    = (PPU_ADDR >= 16'hFE00) && (PPU_ADDR <= 16'hFE9F);
    assign dma_trig   = CPU_WR && (CPU_ADDR == 16'hFF46);
    assign dma_active = (state_q != S_IDLE);
    assign dma_wr     = (state_q == S_WR);

    // DMA sequencer: a FF46 write (re)starts the copy from any state
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        dly_d    = dly_q;
        case (state_q)
            S_DELAY: begin
                if (dly_q == 8'd0) state_d = S_RD;
                else               dly_d   = dly_q - 8'd1;
            end
            S_RD:    state_d = S_WR;
            S_WR: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? S_IDLE : S_RD;
            end
            default: ;
        endcase
        if (dma_trig) begin
            // FE/FF pages alias back onto echo RAM at DE/DF
            src_hi_d = (CPU_DATA_out >= 8'hFE) ? (CPU_DATA_out - 8'h20) : CPU_DATA_out;
            idx_d    = 8'd0;
            dly_d    = DLY_INIT;
            state_d  = S_DELAY;
        end
    end

    assign ppu_grant  = PPU_RD && !dma_wr && !(dma_active && ppu_oam);
    assign cpu_req    = (CPU_RD || CPU_WR) && (cpu_vram || cpu_oam);
    assign cpu_locked = dma_active
                     || (((PPU_MODE == MODE_SCAN) || (PPU_MODE == MODE_DRAW)) && cpu_oam)
                     || ((PPU_MODE == MODE_DRAW) && cpu_vram);
    assign cpu_grant  = cpu_req && !cpu_locked && !dma_wr && !ppu_grant;

    // Port arbitration: DMA write beats PPU beats CPU; address/data hold when idle
    always_comb begin
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_vld_d    = 1'b0;
        rd_own_d    = rd_own_q;
        if (!rst) begin
            if (dma_wr) begin
                mem_wr_c    = 1'b1;
                mem_addr_d  = 16'hFE00 + {8'h00, idx_q};
                mem_wdata_d = SYS_DATA;
            end else if (ppu_grant) begin
                mem_rd_c   = 1'b1;
                mem_addr_d = PPU_ADDR;
                rd_vld_d   = 1'b1;
                rd_own_d   = 1'b1;
            end else if (cpu_grant) begin
                mem_addr_d = CPU_ADDR;
                if (CPU_WR) begin
                    mem_wr_c    = 1'b1;
                    mem_wdata_d = CPU_DATA_out;
                end else begin
                    mem_rd_c = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_own_d = 1'b0;
                end
            end
        end
    end

    // DMA source read: address only moves while a source read is issued
    always_comb begin
        sys_rd_c   = !rst && (state_q == S_RD);
        sys_addr_d = sys_rd_c ? {src_hi_q, idx_q} : sys_addr_q;
    end

    assign MEM_RD      = mem_rd_c;
    assign MEM_WR      = mem_wr_c;
    assign MEM_ADDR    = mem_addr_d;
    assign MEM_WDATA   = mem_wdata_d;
    assign SYS_RD      = sys_rd_c;
    assign SYS_ADDR    = sys_addr_d;
    assign DMA_ACTIVE  = dma_active;
    assign CPU_DATA_in = (rd_vld_q && !rd_own_q) ? MEM_RDATA : 8'hFF;
    assign PPU_DATA_in = (rd_vld_q &&  rd_own_q) ? MEM_RDATA : 8'hFF;

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 8'd0;
            src_hi_q    <= 8'd0;
            dly_q       <= 8'd0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
            sys_addr_q  <= 16'd0;
            rd_vld_q    <= 1'b0;
            rd_own_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            src_hi_q    <= src_hi_d;
            dly_q       <= dly_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sys_addr_q  <= sys_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_own_q    <= rd_own_d;
        end
    end

endmodule

// File: tb/tb_ppu_vmem_arbiter.sv
// tb/tb_ppu_vmem_arbiter.sv - scoreboard bench for ppu_vmem_arbiter
module tb_ppu_vmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] CPU_ADDR;
    logic        CPU_RD, CPU_WR;
    logic [7:0]  CPU_DATA_out, CPU_DATA_in;
    logic [1:0]  PPU_MODE;
    logic        PPU_RD;
    logic [15:0] PPU_ADDR;
    logic [7:0]  PPU_DATA_in;
    logic [15:0] SYS_ADDR;
    logic        SYS_RD;
    logic [7:0]  SYS_DATA;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD, MEM_WR;
    logic [7:0]  MEM_WDATA, MEM_RDATA;
    logic        DMA_ACTIVE;

    always #5 clk = ~clk;

    ppu_vmem_arbiter dut (
        .clk(clk), .rst(rst),
        .CPU_ADDR(CPU_ADDR), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
        .CPU_DATA_out(CPU_DATA_out), .CPU_DATA_in(CPU_DATA_in),
        .PPU_MODE(PPU_MODE), .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR), .PPU_DATA_in(PPU_DATA_in),
        .SYS_ADDR(SYS_ADDR), .SYS_RD(SYS_RD), .SYS_DATA(SYS_DATA),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .DMA_ACTIVE(DMA_ACTIVE)
    );

    int total, bad;
    int act_cnt, wr_cnt;

    logic [7:0]  cpu_q[$];
    logic [7:0]  ppu_q[$];
    logic [15:0] mr_q[$];
    logic [15:0] sys_q[$];
    logic [23:0] wr_q[$];

    logic [7:0]  ram [0:65535];
    logic [7:0]  mem_rd_nx, sys_nx;
    logic        cpu_pend, ppu_pend;
    logic [23:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sysfun(input logic [15:0] a);
        return (a[15:8] == 8'hC1) ? (a[7:0] ^ 8'hA5) : (a[7:0] ^ 8'h3C);
    endfunction

    // Video RAM and system bus responders (registered read data)
    always @(negedge clk) begin
        if (MEM_WR) ram[MEM_ADDR] = MEM_WDATA;
        mem_rd_nx = MEM_RD ? ram[MEM_ADDR] : 8'h00;
        sys_nx    = SYS_RD ? sysfun(SYS_ADDR) : 8'h00;
    end

    always @(posedge clk) begin
        MEM_RDATA <= mem_rd_nx;
        SYS_DATA  <= sys_nx;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            cpu_pend = 1'b0;
            ppu_pend = 1'b0;
        end else begin
            if (cpu_pend) begin
                if (cpu_q.size() > 0) chk("cpu_rdata", CPU_DATA_in, cpu_q.pop_front());
                else                  chk("cpu_q_underflow", 1, 0);
            end
            if (ppu_pend) begin
                if (ppu_q.size() > 0) chk("ppu_rdata", PPU_DATA_in, ppu_q.pop_front());
                else                  chk("ppu_q_underflow", 1, 0);
            end
            cpu_pend = CPU_RD;
            ppu_pend = PPU_RD;
        end
        if (MEM_RD && MEM_WR) chk("mem_rd_wr_both", 1, 0);
        if (MEM_RD) begin
            if (mr_q.size() > 0) chk("mem_rd_addr", MEM_ADDR, mr_q.pop_front());
            else                 chk("mem_rd_unexpected", {16'h0, MEM_ADDR}, 32'h0);
        end
        if (MEM_WR) begin
            if (wr_q.size() > 0) begin
                mon_e = wr_q.pop_front();
                chk("mem_wr", {MEM_ADDR, MEM_WDATA}, mon_e);
                wr_cnt++;
            end else begin
                chk("mem_wr_unexpected", {MEM_ADDR, MEM_WDATA}, 32'h0);
            end
        end
        if (SYS_RD) begin
            if (sys_q.size() > 0) chk("sys_addr", SYS_ADDR, sys_q.pop_front());
            else                  chk("sys_rd_unexpected", {16'h0, SYS_ADDR}, 32'h0);
        end
        if (DMA_ACTIVE) act_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        CPU_RD = 1'b0;
        CPU_WR = 1'b0;
        PPU_RD = 1'b0;
    endtask

    task automatic step();
        tick();
        idle();
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input bit granted);
        CPU_ADDR = a;
        CPU_RD   = 1'b1;
        cpu_q.push_back(exp);
        if (granted) mr_q.push_back(a);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit granted);
        CPU_ADDR     = a;
        CPU_DATA_out = d;
        CPU_WR       = 1'b1;
        if (granted) wr_q.push_back({a, d});
    endtask

    task automatic ppu_read(input logic [15:0] a, input logic [7:0] exp, input bit granted);
        PPU_ADDR = a;
        PPU_RD   = 1'b1;
        ppu_q.push_back(exp);
        if (granted) mr_q.push_back(a);
    endtask

    task automatic push_dma(input logic [7:0] hi);
        logic [15:0] s;
        for (int i = 0; i < 160; i++) begin
            s = {hi, 8'(i)};
            sys_q.push_back(s);
            wr_q.push_back({16'hFE00 + 16'(i), sysfun(s)});
        end
    endtask

    task automatic flush_dma();
        sys_q.delete();
        wr_q.delete();
    endtask

    initial begin
        total = 0; bad = 0; act_cnt = 0; wr_cnt = 0;
        rst = 1'b1; CPU_ADDR = 16'h0; CPU_DATA_out = 8'h0; PPU_MODE = 2'd0; PPU_ADDR = 16'h0;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dma_active", DMA_ACTIVE, 0);
        chk("rst_mem_rd", MEM_RD, 0);
        chk("rst_mem_wr", MEM_WR, 0);
        chk("rst_sys_rd", SYS_RD, 0);
        chk("rst_cpu_data", CPU_DATA_in, 8'hFF);
        chk("rst_ppu_data", PPU_DATA_in, 8'hFF);
        chk("rst_mem_addr", MEM_ADDR, 16'h0);
        chk("rst_sys_addr", SYS_ADDR, 16'h0);
        chk("rst_mem_wdata", MEM_WDATA, 8'h0);
        tick();

        // H_BLANK: open access, region edges, port contention
        cpu_write(16'h8000, 8'h5A, 1); step();
        cpu_read (16'h8000, 8'h5A, 1); step();
        cpu_write(16'hFE10, 8'h11, 1); step();
        cpu_write(16'h8010, 8'h77, 1); step();
        cpu_write(16'hFE9F, 8'hE1, 1); step();
        cpu_read (16'hFEA0, 8'hFF, 0); step();
        cpu_read (16'hFE9F, 8'hE1, 1); step();
        cpu_read (16'hC000, 8'hFF, 0); step();
        cpu_write(16'hA000, 8'h12, 0); step();
        cpu_read (16'h8000, 8'hFF, 0); ppu_read(16'h8010, 8'h77, 1); step();

        // DRAW: CPU locked out of VRAM and OAM, PPU still served
        PPU_MODE = 2'd3;
        cpu_read (16'h9800, 8'hFF, 0); step();
        cpu_write(16'hFE10, 8'h33, 0); step();
        ppu_read (16'hFE10, 8'h11, 1); step();
        // SCAN: only OAM locked
        PPU_MODE = 2'd2;
        cpu_read (16'h8000, 8'h5A, 1); step();
        cpu_read (16'hFE00, 8'hFF, 0); step();
        PPU_MODE = 2'd0;
        cpu_read (16'hFE10, 8'h11, 1); step();
        step();

        // Full DMA from C100 with CPU and PPU traffic on chosen cycles
        act_cnt = 0; wr_cnt = 0;
        cpu_write(16'hFF46, 8'hC1, 0); push_dma(8'hC1); step();
        for (int c = 1; c <= 325; c++) begin
            if (c == 1 || c == 3 || c == 321) cpu_read(16'hFE00, 8'hFF, 0);
            if (c == 2 || c == 160 || c == 320) cpu_read(16'h8000, 8'hFF, 0);
            if (c == 322) cpu_read(16'h8000, 8'h5A, 1);
            if (c == 20) ppu_read(16'hFE04, 8'hFF, 0);
            if (c == 21) ppu_read(16'h8010, 8'hFF, 0);
            if (c == 22) ppu_read(16'h8010, 8'h77, 1);
            step();
        end
        chk("dma_active_cycles", act_cnt, 321);
        chk("dma_write_count", wr_cnt, 160);
        chk("dma_sys_drained", sys_q.size(), 0);
        chk("dma_active_end", DMA_ACTIVE, 0);
        cpu_read(16'hFE9F, 8'h3A, 1); step();
        cpu_read(16'hFE00, 8'hA5, 1); step();
        step();

        // Restart at cycle 50, then reset at cycle 100 of the second copy
        wr_cnt = 0;
        cpu_write(16'hFF46, 8'hC1, 0); push_dma(8'hC1); step();
        repeat (49) step();
        cpu_write(16'hFF46, 8'hD0, 0); step();
        chk("dma1_writes", wr_cnt, 24);
        flush_dma(); wr_cnt = 0; push_dma(8'hD0);
        repeat (99) step();
        rst = 1'b1;
        flush_dma();
        chk("dma2_writes", wr_cnt, 49);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_dma_active", DMA_ACTIVE, 0);
        tick();
        repeat (4) step();
        cpu_read(16'hFE00, 8'h3C, 1); step();
        cpu_read(16'hFE30, 8'h0C, 1); step();
        cpu_read(16'hFE31, 8'h94, 1); step();
        step();

        // FE source page is clamped to DE
        wr_cnt = 0;
        cpu_write(16'hFF46, 8'hFE, 0); push_dma(8'hDE); step();
        repeat (5) step();
        rst = 1'b1;
        flush_dma();
        chk("clamp_writes", wr_cnt, 2);
        tick();
        rst = 1'b0;
        step();
        step();

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("ppu_q_drained", ppu_q.size(), 0);
        chk("mr_q_drained", mr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppu_vmem_arbiter.md
Name: ppu_vmem_arbiter

Overview:
- Owns the single video-memory port (VRAM 8000-9FFF, OAM FE00-FE9F) and shares it between three requesters: CPU, PPU fetcher and an internal OAM DMA engine.
- Snoops CPU writes to FF46 and runs the 160-byte OAM DMA copy: source reads go over the system bus, destination writes go to OAM.
- Enforces Game Boy access locking from PPU_MODE: OAM is locked in SCAN; OAM and VRAM are locked in DRAW. Blocked CPU reads return FF; blocked CPU writes are dropped.
- Sits between the CPU bus decoder, the PPU, and the VRAM/OAM RAM.

Parameters:
- DMA_LEN, 160, bytes copied per DMA.
- DMA_START_DELAY, 1, idle cycles between the FF46 write and the first source read.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- CPU_ADDR  in  16  CPU address
- CPU_RD  in  1  CPU read strobe
- CPU_WR  in  1  CPU write strobe
- CPU_DATA_out  in  8  CPU write data
- CPU_DATA_in  out  8  read data returned to CPU (video regions only)
- PPU_MODE  in  2  0=H_BLANK, 1=V_BLANK, 2=SCAN, 3=DRAW
- PPU_RD  in  1  PPU read request
- PPU_ADDR  in  16  PPU read address
- PPU_DATA_in  out  8  read data returned to PPU
- SYS_ADDR  out  16  DMA source address to system bus
- SYS_RD  out  1  DMA source read strobe
- SYS_DATA  in  8  system bus read data, valid the cycle after SYS_RD
- MEM_ADDR  out  16  video RAM address
- MEM_RD  out  1  video RAM read
- MEM_WR  out  1  video RAM write
- MEM_WDATA  out  8  video RAM write data
- MEM_RDATA  in  8  video RAM read data, registered (valid the cycle after MEM_RD)
- DMA_ACTIVE  out  1  high while a DMA is running

Behaviour:
- Region decode: VRAM = 8000-9FFF; OAM = FE00-FE9F. CPU accesses outside both regions are ignored; MEM_* stays idle for them.
- Reset: DMA FSM goes to IDLE. DMA_ACTIVE, SYS_RD, MEM_RD and MEM_WR are 0. SYS_ADDR, MEM_ADDR and MEM_WDATA are 0. CPU_DATA_in and PPU_DATA_in are FF. The return-owner register is NONE.
- DMA FSM states: IDLE -> DELAY (DMA_START_DELAY cycles) -> RD -> WR -> RD ... -> IDLE.
  - Trigger: CPU_WR with CPU_ADDR=FF46 latches src_hi=CPU_DATA_out, clears idx, and enters DELAY on the next edge. DMA_ACTIVE is 1 from that edge.
  - src_hi FE or FF is clamped to src_hi-0x20 (DE/DF).
  - RD: SYS_RD=1, SYS_ADDR={src_hi, idx}.
  - WR: MEM_WR=1, MEM_ADDR=FE00+idx, MEM_WDATA=SYS_DATA; idx increments. If idx was DMA_LEN-1, go to IDLE and DMA_ACTIVE drops on that edge.
  - Total: DMA_START_DELAY + 2*DMA_LEN cycles from trigger to DMA_ACTIVE=0 (321 at defaults).
  - An FF46 write during an active DMA restarts it: new src_hi, idx=0, state DELAY. Bytes already copied stay in OAM.
  - Reset mid-DMA aborts immediately. OAM keeps any partial contents.
- Grant priority each cycle: DMA-WR > PPU > CPU. Exactly one of MEM_RD/MEM_WR may be high per cycle.
- PPU grant: PPU_RD=1 and no DMA-WR this cycle.
  - While DMA_ACTIVE and PPU_ADDR is in OAM, the PPU read is not issued and PPU_DATA_in returns FF next cycle.
- CPU grant: CPU access to VRAM/OAM, not locked, and the port is free.
  - Locked when any of: DMA_ACTIVE (all video regions); PPU_MODE=SCAN and OAM; PPU_MODE=DRAW and VRAM or OAM.
  - Locked or port-busy reads return FF. Locked or port-busy writes are dropped with no retry.
- Read return: a 1-bit owner register records who issued MEM_RD. Next cycle the owner's data port gets MEM_RDATA; the other port gets FF. Both outputs hold FF when no read was issued.
- MEM_ADDR with no grant holds its last value. SYS_ADDR holds its last value outside RD.

Test Plan:
- Reset then idle → DMA_ACTIVE=0, MEM_RD=MEM_WR=0, CPU_DATA_in=PPU_DATA_in=FF.
- Mode H_BLANK: CPU write 8000<=5A, then read 8000 → MEM_WR with data 5A; next read returns CPU_DATA_in=5A one cycle after CPU_RD.
- Mode DRAW: CPU read 9800 and write FE10<=33 → no MEM strobes, CPU_DATA_in=FF, a later H_BLANK read of FE10 returns old value. Mode SCAN: CPU read 8000 granted, read FE00 returns FF.
- Write FF46<=C1, system memory C100+i = i^A5 → DMA_ACTIVE high for exactly 321 cycles, SYS_RD at C100..C19F, OAM FE00+i = i^A5; CPU OAM/VRAM reads return FF throughout.
- DMA running, PPU_RD to FE04 and to 8010 on a DMA-WR cycle → FE04 returns FF; 8010 is not issued that cycle and returns FF; 8010 is issued and returns data on a non-WR cycle.
- FF46<=C1, then FF46<=D0 at cycle 50, then rst at cycle 100 of the second DMA → restart from D000 with idx=0; reset clears DMA_ACTIVE on the next edge, no further MEM_WR.
